// File: rtl/blur_port_arbiter.sv
// Three-port round-robin arbiter in front of a single-port row SRAM for the blur engine.
// The grant is a register. An owner that asserts lock may keep the port, but only for up
// to LOCK_MAX consecutive locked accesses while another requester is waiting.
module blur_port_arbiter #(
  parameter int unsigned DW       = 5120,
  parameter int unsigned AW       = 9,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    req,
  input  logic [2:0]    lock,
  input  logic [2:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  output logic [2:0]    gnt,
  output logic [2:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int unsigned CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0] CntMax = CW'(LOCK_MAX - 1);

  logic [2:0]    gnt_q, gnt_d;
  logic [2:0]    rvalid_q, rvalid_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  logic [2:0] access;
  logic       owner_locked;
  logic       others_waiting;
  logic       keep;
  logic       pick_valid;
  logic [1:0] pick_idx;

  // An access happens only where the registered grant meets a live request.
  assign access         = gnt_q & req;
  assign owner_locked   = |(access & lock);
  assign others_waiting = |(req & ~gnt_q);
  assign keep           = owner_locked && !((lock_cnt_q == CntMax) && others_waiting);

  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  assign rdata  = mem_dout;

  // SRAM port mux; idle cycles drive all zeros.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    unique case (access)
      3'b001: begin
        mem_we   = we[0];
        mem_addr = addr0;
        mem_din  = din0;
      end
      3'b010: begin
        mem_we   = we[1];
        mem_addr = addr1;
        mem_din  = din1;
      end
      3'b100: begin
        mem_we   = we[2];
        mem_addr = addr2;
        mem_din  = din2;
      end
      default: ;
    endcase
  end

  // Round-robin search starting at last_q+1. The current owner (== last_q) comes last,
  // so it is re-picked only when nobody else is waiting.
  always_comb begin
    int tmp;
    pick_valid = 1'b0;
    pick_idx   = last_q;
    tmp        = 0;
    // Walk the candidates from farthest to nearest so the nearest hit wins.
    for (int k = 3; k >= 1; k--) begin
      tmp = (int'(last_q) + k) % 3;
      if (req[tmp]) begin
        pick_valid = 1'b1;
        pick_idx   = 2'(tmp);
      end
    end
  end

  // Next grant, round-robin pointer, lock counter and read-valid.
  always_comb begin
    gnt_d      = 3'b000;
    last_d     = last_q;
    lock_cnt_d = '0;
    rvalid_d   = access & ~we;
    if (keep) begin
      gnt_d      = gnt_q;
      lock_cnt_d = (lock_cnt_q == CntMax) ? lock_cnt_q : lock_cnt_q + 1'b1;
    end else if (pick_valid) begin
      gnt_d  = 3'b001 << pick_idx;
      last_d = pick_idx;
    end
  end

  // State registers; reset leaves requester 0 as the first winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q      <= 3'b000;
      rvalid_q   <= 3'b000;
      last_q     <= 2'd2;
      lock_cnt_q <= '0;
    end else begin
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

endmodule

// File: tb/tb_blur_port_arbiter.sv
// Self-checking bench for blur_port_arbiter: a directed vector table, hand-written corner
// sequences and a randomized run checked against a behavioural arbitration model.
module tb_blur_port_arbiter;

  localparam int unsigned DW       = 5120;
  localparam int unsigned AW       = 9;
  localparam int unsigned LOCK_MAX = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    req = '0, lock = '0, we = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0, addr2 = '0;
  logic [DW-1:0] din0 = '0, din1 = '0, din2 = '0, mem_dout = '0;
  logic [2:0]    gnt, rvalid;
  logic [DW-1:0] rdata, mem_din;
  logic          mem_we;
  logic [AW-1:0] mem_addr;

  int n_total = 0;
  int n_bad   = 0;

  blur_port_arbiter #(.DW(DW), .AW(AW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .din0(din0), .din1(din1), .din2(din2),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h (low 64 bits)", name, act[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] v;
    for (int w = 0; w < int'(DW / 32); w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  // Holds reset for two cycles, checks the reset state, returns at a falling edge.
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; req = '0; lock = '0; we = '0;
    #1;
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_rvalid", rvalid, 3'b000);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0]    req, lock, we;
    logic [2:0]    gnt, rv;
    logic          mwe;
    logic [AW-1:0] maddr;
  } vec_t;

  vec_t tbl[11];

  // Behavioural model: owner index (-1 = none), last winner, locked-keep streak.
  int       m_own, m_last, m_cnt;
  bit [2:0] m_rv;

  initial begin
    logic [DW-1:0] ones;
    logic [AW-1:0] a[3];
    logic [DW-1:0] d[3];
    logic [2:0]    eg;
    bit            acc, others;
    int            nxt, idx;
    ones = '1;

    // Rows: inputs for the cycle, then expected gnt, rvalid, mem_we, mem_addr that cycle.
    tbl[0]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 9'd0};
    tbl[1]  = '{3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 1'b0, 9'd5};
    tbl[2]  = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 1'b0, 9'd0};
    tbl[3]  = '{3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 9'd0};
    tbl[4]  = '{3'b111, 3'b000, 3'b010, 3'b010, 3'b000, 1'b1, 9'd17};
    tbl[5]  = '{3'b111, 3'b000, 3'b000, 3'b100, 3'b000, 1'b0, 9'd479};
    tbl[6]  = '{3'b111, 3'b000, 3'b000, 3'b001, 3'b100, 1'b0, 9'd5};
    tbl[7]  = '{3'b100, 3'b100, 3'b000, 3'b010, 3'b001, 1'b0, 9'd0};
    tbl[8]  = '{3'b100, 3'b100, 3'b000, 3'b100, 3'b000, 1'b0, 9'd479};
    tbl[9]  = '{3'b000, 3'b100, 3'b000, 3'b100, 3'b100, 1'b0, 9'd0};
    tbl[10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 9'd0};

    // Directed table: single read, req drop, rotation with write, lock, idle.
    reset_dut();
    addr0 = 9'd5; addr1 = 9'd17; addr2 = 9'd479;
    for (int i = 0; i < 11; i++) begin
      req = tbl[i].req; lock = tbl[i].lock; we = tbl[i].we;
      mem_dout = rand_wide();
      #1;
      chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_rvalid", i), rvalid, tbl[i].rv);
      chk($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].mwe);
      chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].maddr);
      if (tbl[i].rv != 3'b000) chk($sformatf("tbl%0d_rdata", i), rdata, mem_dout);
      @(negedge clk);
    end

    // Rotation from reset.
    reset_dut();
    req = 3'b111; lock = '0; we = '0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rot%0d_gnt", i), gnt, 3'b001 << (i % 3));
      @(negedge clk);
    end

    // Lock starvation guard: requester 1 locked, requester 2 waiting.
    reset_dut();
    req = 3'b110; lock = 3'b010;
    @(negedge clk);
    for (int i = 0; i < int'(LOCK_MAX); i++) begin
      #1;
      chk($sformatf("lock%0d_gnt", i), gnt, 3'b010);
      @(negedge clk);
    end
    #1;
    chk("lock_release_gnt", gnt, 3'b100);

    // Write with all-ones data: one write cycle, no rvalid.
    reset_dut();
    req = 3'b100; we = 3'b100; lock = '0; addr2 = 9'd479; din2 = ones;
    @(negedge clk);
    #1;
    chk("wr_gnt", gnt, 3'b100);
    chk("wr_mem_we", mem_we, 1'b1);
    chk("wr_mem_addr", mem_addr, 9'd479);
    chk("wr_mem_din", mem_din, ones);
    @(negedge clk);
    req = 3'b000;
    #1;
    chk("wr_rvalid", rvalid, 3'b000);
    chk("wr_after_mem_we", mem_we, 1'b0);
    chk("wr_after_mem_din", mem_din, '0);
    we = '0;

    // Reset in the middle of a read access.
    reset_dut();
    req = 3'b010;
    @(posedge clk);
    #2;
    chk("mid_gnt_before", gnt, 3'b010);
    chk("mid_mem_addr_before", mem_addr, 9'd17);
    rst = 1'b1;
    #1;
    chk("mid_gnt_async", gnt, 3'b000);
    chk("mid_rvalid_async", rvalid, 3'b000);
    chk("mid_mem_addr_async", mem_addr, '0);
    @(negedge clk);
    req = 3'b011;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_gnt_released", gnt, 3'b000);
    @(posedge clk);
    #1;
    chk("mid_gnt_after", gnt, 3'b001);
    chk("mid_rvalid_after", rvalid, 3'b000);

    // Randomized run against the behavioural model.
    reset_dut();
    m_own = -1; m_last = 2; m_cnt = 0; m_rv = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int j = 0; j < 3; j++) begin
        req[j]  = ($urandom_range(3) != 0);
        lock[j] = ($urandom_range(3) != 0);
        we[j]   = $urandom_range(1);
      end
      addr0 = AW'($urandom()); addr1 = AW'($urandom()); addr2 = AW'($urandom());
      din0 = rand_wide(); din1 = rand_wide(); din2 = rand_wide();
      mem_dout = rand_wide();
      a[0] = addr0; a[1] = addr1; a[2] = addr2;
      d[0] = din0;  d[1] = din1;  d[2] = din2;
      #1;
      eg  = (m_own >= 0) ? (3'b001 << m_own) : 3'b000;
      acc = (m_own >= 0) && req[m_own];
      chk("rnd_gnt", gnt, eg);
      chk("rnd_rvalid", rvalid, m_rv);
      chk("rnd_mem_we", mem_we, acc ? we[m_own] : 1'b0);
      chk("rnd_mem_addr", mem_addr, acc ? a[m_own] : '0);
      chk("rnd_mem_din", mem_din, acc ? d[m_own] : '0);
      chk("rnd_rdata", rdata, mem_dout);
      // Advance the model by one clock.
      m_rv = '0;
      if (acc && !we[m_own]) m_rv[m_own] = 1'b1;
      others = 1'b0;
      for (int j = 0; j < 3; j++) if (j != m_own && req[j]) others = 1'b1;
      if (acc && lock[m_own] && !(m_cnt == int'(LOCK_MAX) - 1 && others)) begin
        if (m_cnt < int'(LOCK_MAX) - 1) m_cnt++;
      end else begin
        nxt = -1;
        for (int k = 1; k <= 3; k++) begin
          idx = (m_last + k) % 3;
          if (req[idx] && nxt < 0) nxt = idx;
        end
        m_own = nxt;
        if (nxt >= 0) m_last = nxt;
        m_cnt = 0;
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/blur_port_arbiter.md
BLUR_PORT_ARBITER -- requirements
Module: blur_port_arbiter

Interface
REQ-001 The block SHALL have the following parameters:
  - DW, default 5120, data width of one blurred-image row;
  - AW, default 9, row address width;
  - LOCK_MAX, default 16, maximum consecutive locked accesses while another requester waits.
REQ-002 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-003 The block SHALL have the following ports:
  - clk  in  1  -- rising-edge clock;
  - rst  in  1  -- async active-high reset;
  - req  in  3  -- per-requester access request;
  - lock  in  3  -- per-requester hold-grant request;
  - we  in  3  -- per-requester write enable (0 = read);
  - addr0/addr1/addr2  in  AW each  -- requester addresses;
  - din0/din1/din2  in  DW each  -- requester write data;
  - gnt  out  3  -- registered one-hot grant;
  - rvalid  out  3  -- read data valid, per requester;
  - rdata  out  DW  -- shared read data, equal to mem_dout;
  - mem_we  out  1  -- SRAM write enable;
  - mem_addr  out  AW  -- SRAM address;
  - mem_din  out  DW  -- SRAM write data;
  - mem_dout  in  DW  -- SRAM read data, valid one cycle after address.

Function
REQ-004 gnt SHALL be a register that is either all-zero or exactly one-hot.
REQ-005 Access rule: an access by requester i SHALL occur in a cycle where gnt[i]=1 and req[i]=1 (access_i).
REQ-006 During access_i:
  - mem_addr = addr_i;
  - mem_din = din_i;
  - mem_we = we[i].
REQ-007 With no access, mem_we, mem_addr and mem_din SHALL be 0.
REQ-008 rvalid[i] SHALL be registered, set to 1 in the cycle after a read access_i (we[i]=0), else 0.
REQ-009 rdata SHALL be a combinational pass-through of mem_dout.
REQ-010 Grant keep condition, at each clock edge: gnt holds its value iff all of the following are true:
  - access_i occurred;
  - lock[i]=1;
  - NOT (lock_cnt = LOCK_MAX-1 and any other req bit set).
REQ-011 Otherwise the next gnt SHALL be a round-robin pick among req bits, searching from last_q+1 modulo 3.
REQ-012 If no req bits are set, the next gnt SHALL be 0.
REQ-013 The round-robin may re-pick the current owner only when no other requester is pending.
REQ-014 last_q (2 bits, values 0..2) SHALL update to the index of every newly issued grant, and SHALL be unchanged when gnt goes to 0.
REQ-015 Latency: request-to-grant SHALL be 1 cycle (req rises in cycle n, gnt in cycle n+1, access in cycle n+1).
REQ-016 Latency: read-access-to-rvalid SHALL be 1 cycle.
REQ-017 Throughput: a sole requester holding req=1 SHALL get one access every cycle with no bubble, locked or not.
REQ-018 Fairness: with all three requesters unlocked and continuously requesting, accesses SHALL rotate 0,1,2,0,... (after reset, last_q=2).
REQ-019 lock_cnt SHALL:
  - increment on each locked keep;
  - clear to 0 on any new grant or when gnt=0;
  - saturate at LOCK_MAX-1.
REQ-020 A forced release by lock_cnt SHALL hand the grant to the next waiting requester in round-robin order, never to the current owner.
REQ-021 If a granted requester drops req, no access SHALL occur in that cycle, and the grant SHALL be re-arbitrated at the next edge.
REQ-022 Changes on req, we or addr of non-granted requesters SHALL have no effect on mem_* outputs.
REQ-023 lock asserted without req, or by a non-owner, SHALL have no effect.

Reset
REQ-024 While rst=1 (asynchronous), the following SHALL hold: gnt=0, rvalid=0, last_q=2, lock_cnt=0; hence mem_we=0, mem_addr=0, mem_din=0.
REQ-025 Reset during an access SHALL abort it immediately; no rvalid SHALL follow.
REQ-026 After rst falls, arbitration SHALL resume from last_q=2, so requester 0 wins first.

Verification
REQ-027 Scenario "single read": req=001, we=000, addr0=5 at cycle 0 -> gnt=001 at cycle 1, mem_addr=5, mem_we=0; rvalid=001 at cycle 2 with rdata=mem_dout.
REQ-028 Scenario "rotation": req=111 unlocked for 6 cycles from reset -> gnt sequence 001,010,100,001,010,100.
REQ-029 Scenario "lock starvation guard": requester 1 with req=lock=1, requester 2 with req=1, LOCK_MAX=16 -> 16 consecutive requester-1 accesses, then gnt=100.
REQ-030 Scenario "write": req=100, we=100, addr2=479, din2=all-ones -> mem_we=1, mem_addr=479, mem_din=all-ones for one cycle; rvalid stays 000.
REQ-031 Scenario "mid-access reset": gnt=010 with a read access, rst pulsed for 1 cycle -> gnt=000 and rvalid=000 asynchronously; after release with req=011 -> gnt=001.
REQ-032 Scenario "req drop": gnt=001 and req0 falls -> mem_we=0, mem_addr=0 that cycle; next gnt goes to any pending requester, or 000.
